vsd_serializer_v1: RTL and testbench
====================================

VSD_SERIALIZER_V1 -- requirements
Module: vsd_serializer_v1

Interface
REQ-001 Parameter: WIDTH, default 10, parallel word width in bits (legal range 2..32).
REQ-002 Port order SHALL be clk, rst_n, load, data_in, data_out, so that positional instantiation works.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  synchronous parallel-load strobe, active-high, sampled on rising clk.
REQ-006 data_in  input  WIDTH  parallel word; sampled only on an edge where load=1.
REQ-007 data_out  output  1  serial bit stream, MSB first, driven directly from a register.

Function
REQ-008 Internal state SHALL consist of a WIDTH-bit shift register, a bit counter (0..WIDTH) and a two-state FSM: IDLE and SHIFT.
REQ-009 data_out SHALL always equal shift_reg[WIDTH-1]; there is no combinational path from any input to data_out.
REQ-010 Rising edge with load=1 (any state): shift_reg <= data_in, counter <= WIDTH-1, state <= SHIFT.
REQ-011 Latency: data_in[WIDTH-1] SHALL appear on data_out immediately after the load edge; data_in[WIDTH-1-k] SHALL appear after the k-th subsequent edge, for k=0..WIDTH-1.
REQ-012 In SHIFT with load=0, each rising edge: shift_reg <= {shift_reg[WIDTH-2:0], 1'b0}, counter decrements.
REQ-013 In SHIFT, the edge on which counter=0 and load=0 SHALL perform the final shift and move to IDLE; data_out is then 0.
REQ-014 In IDLE with load=0, shift_reg SHALL hold its value (all zeros after a completed word), so data_out stays 0.
REQ-015 Load during SHIFT SHALL abort the current word without error; the new word starts immediately per REQ-010.
REQ-016 load held high on consecutive edges SHALL reload every edge, so data_out repeatedly shows the MSB of the latest data_in.
REQ-017 data_in changes while load=0 SHALL have no effect.
REQ-018 Exactly WIDTH valid bits per load; the bit that follows the LSB is 0.

Reset
REQ-019 rst_n=0 SHALL asynchronously force shift_reg=0, counter=0, state=IDLE, hence data_out=0, regardless of clk.
REQ-020 Reset asserted mid-word SHALL discard the word; after rst_n deasserts the block stays in IDLE with data_out=0 until the next load.
REQ-021 load on the first rising edge after reset deassertion SHALL be honoured normally.

Structure
REQ-022 The FSM state encoding (IDLE, SHIFT) and the default WIDTH constant SHALL reside in a shared package, vsd_serializer_pkg.
REQ-023 The block SHALL be a single module with no sub-modules; the shift register, counter and FSM are inline sequential logic.

Verification
REQ-024 Reset: hold rst_n=0 for 10 ns with clk running -> data_out=0 throughout; after release with load=0 -> data_out remains 0.
REQ-025 Single word: load=1 with data_in=10'h2B5 for one edge -> data_out over the next 10 cycles = 1,0,1,0,1,1,0,1,0,1, then 0 indefinitely.
REQ-026 Mid-word reload: load 10'h3FF, after 4 cycles load 10'h001 -> data_out = 1,1,1,1, then 0×9, then 1, then 0.
REQ-027 Async reset mid-word: load 10'h3FF, assert rst_n low 3 cycles later, between clock edges -> data_out drops to 0 immediately and stays 0 after release.
REQ-028 Continuous load: hold load=1 while toggling data_in between 10'h200 and 10'h000 -> data_out follows the data_in MSB one edge later.
REQ-029 Random: 100 random words, each loaded once and followed by 10 idle cycles -> the 10 serial bits reassemble to the loaded word, and data_out=0 between words.

Source files
------------

// File: rtl/vsd_serializer_pkg.sv
// Shared definitions for the MSB-first parallel-to-serial converter.
package vsd_serializer_pkg;

    localparam int DEFAULT_WIDTH = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/vsd_serializer_v1.sv
// Parallel-load, MSB-first serializer. data_out comes straight from the top
// bit of the shift register, so it cannot glitch with the inputs. Zeros are
// shifted in from the bottom, which leaves the line at 0 once a word is done.
module vsd_serializer_v1
    import vsd_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_out
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    // Next state: load wins in any state; otherwise shift while in SHIFT.
    // cnt_q counts the shifts still to come before the word is exhausted.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = data_in;
            cnt_d   = CW'(WIDTH - 1);
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out = shift_q[WIDTH-1];

endmodule

// File: tb/tb_vsd_serializer_v1.sv
// Self-checking bench: a queue-of-bits model is compared against data_out on
// every falling edge, plus literal bit sequences for the directed scenarios.
module tb_vsd_serializer_v1;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_out;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    vsd_serializer_v1 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a load queues the word's bits MSB first and presents the first
    // one; every other edge presents the next queued bit, or 0 when none remain.
    bit   q[$];
    logic exp_out = 1'b0;

    function automatic logic model_step(input logic ld, input logic [W-1:0] d);
        if (ld) begin
            q.delete();
            for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
        end
        if (q.size() > 0) return q.pop_front();
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_out <= 1'b0;
        end else begin
            exp_out <= model_step(load, data_in);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) check("cycle", {31'd0, data_out}, {31'd0, exp_out});
    end

    // Apply inputs for one edge (called just after a falling edge) and
    // sample data_out on the following falling edge.
    task automatic cyc(input logic ld, input logic [W-1:0] d, output logic b);
        load    = ld;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
        b = data_out;
    endtask

    initial begin
        logic        b;
        logic [14:0] seq15;
        logic [9:0]  seq10;
        logic [W-1:0] word, got;

        // Reset held for 10 ns with clock running
        cmp_en = 1'b1;
        #1 check("reset_out", {31'd0, data_out}, 32'd0);
        @(negedge clk);
        check("reset_hold", {31'd0, data_out}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, W'($urandom), b);
            check("post_reset_idle", {31'd0, b}, 32'd0);
        end

        // Single word 0x2B5
        cyc(1'b1, 10'h2B5, b);
        seq10[9] = b;
        for (int i = 8; i >= 0; i--) begin
            cyc(1'b0, W'($urandom), b);
            seq10[i] = b;
        end
        check("word_2b5", {22'd0, seq10}, 32'h2B5);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, W'($urandom), b);
            check("tail_zero", {31'd0, b}, 32'd0);
        end

        // Mid-word reload: 0x3FF, then 0x001 after four bits
        cyc(1'b1, 10'h3FF, b);
        seq15[14] = b;
        for (int i = 13; i >= 0; i--) begin
            cyc((i == 10) ? 1'b1 : 1'b0, (i == 10) ? 10'h001 : 10'h155, b);
            seq15[i] = b;
        end
        check("reload_seq", {17'd0, seq15}, 32'b111100000000010);

        // Async reset mid-word, asserted between edges
        cyc(1'b1, 10'h3FF, b);
        cyc(1'b0, 10'h000, b);
        cyc(1'b0, 10'h000, b);
        check("pre_reset_bit", {31'd0, b}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_drop", {31'd0, data_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 10'h3FF, b);
            check("after_reset_zero", {31'd0, b}, 32'd0);
        end

        // Load on the first edge after reset release is honoured
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        cyc(1'b1, 10'h200, b);
        check("first_edge_load", {31'd0, b}, 32'd1);

        // Continuous load toggling the MSB
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 10'h000 : 10'h200, b);
            check("cont_load", {31'd0, b}, (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        for (int i = 0; i < W + 1; i++) cyc(1'b0, 10'h000, b);
        check("cont_tail", {31'd0, b}, 32'd0);

        // Random words, each loaded once, followed by idle cycles
        for (int n = 0; n < 100; n++) begin
            word = W'($urandom);
            cyc(1'b1, word, b);
            got[W-1] = b;
            for (int i = W - 2; i >= 0; i--) begin
                cyc(1'b0, W'($urandom), b);
                got[i] = b;
            end
            check("rand_word", {22'd0, got}, {22'd0, word});
            cyc(1'b0, W'($urandom), b);
            check("rand_gap", {31'd0, b}, 32'd0);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
